// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU divider.
// Latency: none (package only).
// Backpressure: none (package only).
package div_iter_pkg;

  // Native operand width of the MIPS integer datapath.
  localparam int DIV_WIDTH = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encoding of the 'sign' select produced by the instruction decoder.
  localparam logic SIGN_DIVU = 1'b0;
  localparam logic SIGN_DIV  = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle by the owner.
//
// Ports:
//   rem      partial remainder before this step
//   q_msb    next dividend bit, shifted into the remainder LSB
//   divisor  divisor magnitude
//   rem_next partial remainder after this step
//   q_bit    quotient bit produced by this step
module div_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   diff;

  // Before step i the remainder holds at most i-1 dividend bits, so its
  // MSB is always zero when it is shifted here and can be dropped.
  logic rem_msb_unused;
  assign rem_msb_unused = rem[WIDTH-1];

  assign rem_shift = {rem[WIDTH-2:0], q_msb};

  // One extra bit so the borrow shows up as the sign of the difference.
  assign diff = {1'b0, rem_shift} - {1'b0, divisor};

  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : rem_shift;

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU, EX-stage resident.
// Latency: start sampled at edge T0, ready pulses in cycle T0+ITERS+1.
// Backpressure: raises stall while busy; start outside IDLE is dropped.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   a, b    dividend (rs) and divisor (rt)
//   sign    1 = DIV (signed), 0 = DIVU
//   start   request a division (only looked at in IDLE)
//   annul   pipeline flush; aborts whatever is in flight
//   result  {remainder (HI), quotient (LO)}, held until the next completion
//   ready   one-cycle pulse, result valid in that cycle
//   stall   hold EX and everything upstream
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             q_neg;
  logic             r_neg;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_iter;
  logic             is_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  assign accept    = start & ~annul;
  assign last_iter = (cnt == LAST_ITER);
  assign is_signed = (sign == SIGN_DIV);

  // Two's complement negation of the most negative value wraps to itself,
  // which read as unsigned is exactly the required magnitude 2^(WIDTH-1).
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q_msb    (quo[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  // The final step's outputs are fixed up and registered on the edge that
  // enters DONE, so result is already stable for the whole ready cycle.
  assign q_final = {quo[WIDTH-2:0], step_bit};
  assign q_fixed = q_neg ? (~q_final + 1'b1) : q_final;
  assign r_fixed = r_neg ? (~step_rem + 1'b1) : step_rem;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and control outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = DIV;
          // Stall already in the request cycle so the instruction stays in EX.
          stall      = 1'b1;
        end
      end
      DIV: begin
        stall = 1'b1;
        if (annul) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // No stall here: the pipeline consumes result in this same cycle.
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem     <= '0;
            quo     <= a_mag;
            divisor <= b_mag;
            q_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg   <= is_signed & a[WIDTH-1];
            cnt     <= '0;
          end
        end
        DIV: begin
          if (!annul) begin
            rem <= step_rem;
            quo <= q_final;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              result <= {r_fixed, q_fixed};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
